// File: rtl/pll_resp_pkg.sv
// Shared select codes, state encoding and error flag indices
// for the soft PLL phase-shift responder.
package pll_resp_pkg;

   localparam logic [2:0] SEL_ALL = 3'b000;
   localparam logic [2:0] SEL_M   = 3'b001;
   localparam logic [2:0] SEL_C0  = 3'b010;
   localparam logic [2:0] SEL_C1  = 3'b011;
   localparam logic [2:0] SEL_C2  = 3'b100;
   localparam logic [2:0] SEL_C3  = 3'b101;
   localparam logic [2:0] SEL_C4  = 3'b110;
   localparam logic [2:0] SEL_BAD = 3'b111;

   localparam int ERR_BAD_SEL = 0;
   localparam int ERR_OVERRUN = 1;

   typedef enum logic [1:0] {
      HOLD,
      LOCKING,
      IDLE,
      BUSY
   } state_e;

   // Whether counter idx moves for a given select code
   function automatic logic sel_hits(input logic [2:0] sel,
                                     input int idx);
      case (sel)
         SEL_ALL, SEL_M: return 1'b1;
         SEL_C0:         return idx == 0;
         SEL_C1:         return idx == 1;
         SEL_C2:         return idx == 2;
         SEL_C3:         return idx == 3;
         SEL_C4:         return idx == 4;
         default:        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pll_resp_sync.sv
// Multi-flop synchronizer; RISE=1 turns the output into a
// one-cycle pulse on a synced 0->1 transition.
module pll_resp_sync #(
   parameter int STAGES = 2,
   parameter bit RISE   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              level;

   always_comb begin
      sync_d = (sync_q << 1) | STAGES'(d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
   end

   assign level = sync_q[STAGES-1];

   if (RISE) begin : g_rise
      logic prev_q;
      logic prev_d;
      always_comb prev_d = level;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) prev_q <= 1'b0;
         else        prev_q <= prev_d;
      end
      assign o = level & ~prev_q;
   end else begin : g_level
      assign o = level;
   end

endmodule

// File: rtl/pll_phase_responder.sv
// Soft PLL dynamic phase-shift responder (C0..C4 accumulators).
// Optional clock-source switching: define PLL_RESP_CLKSWITCH_EN.
module pll_phase_responder
   import pll_resp_pkg::*;
#(
   parameter int NUM_C           = 5,
   parameter int STEPS_PER_CYCLE = 64,
   parameter int PHASE_W         = $clog2(STEPS_PER_CYCLE),
   parameter int DONE_LATENCY    = 2,
   parameter int LOCK_CYCLES     = 16,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     scanclk,
   input  logic                     phasestep,
   input  logic [2:0]               phasecounterselect,
   input  logic                     phaseupdown,
   input  logic                     areset,
   input  logic                     clkswitch,
   output logic                     phase_done,
   output logic                     locked,
   output logic [NUM_C*PHASE_W-1:0] phase_out,
   output logic [15:0]              step_count,
   output logic [1:0]               err,
   output logic                     active_clksrc
);

   localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
   localparam logic [PHASE_W-1:0] PH_MAX =
      PHASE_W'(STEPS_PER_CYCLE - 1);

   state_e                          state_q, state_d;
   logic [LCK_W-1:0]                lock_cnt_q, lock_cnt_d;
   logic [2:0]                      busy_cnt_q, busy_cnt_d;
   logic [NUM_C-1:0][PHASE_W-1:0]   acc_q, acc_d;
   logic [15:0]                     step_cnt_q, step_cnt_d;
   logic [1:0]                      err_q, err_d;
   logic                            done_q, done_d;
   logic                            locked_q, locked_d;
   logic                            ps_prev_q, ps_prev_d;

   logic sc_rise;
   logic ps_s;
   logic ar_s;
   logic step_edge;
   logic dir;

   pll_resp_sync #(.STAGES(SYNC_STAGES), .RISE(1'b1)) u_sync_sc (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (scanclk),
      .o     (sc_rise)
   );

   pll_resp_sync #(.STAGES(SYNC_STAGES), .RISE(1'b0)) u_sync_ps (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (phasestep),
      .o     (ps_s)
   );

   pll_resp_sync #(.STAGES(SYNC_STAGES), .RISE(1'b0)) u_sync_ar (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (areset),
      .o     (ar_s)
   );

`ifdef PLL_RESP_CLKSWITCH_EN
   logic cs_rise;
   logic clksrc_q, clksrc_d;

   pll_resp_sync #(.STAGES(SYNC_STAGES), .RISE(1'b1)) u_sync_cs (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (clkswitch),
      .o     (cs_rise)
   );
`else
   logic unused_clkswitch;
   assign unused_clkswitch = clkswitch;
`endif

   function automatic logic [PHASE_W-1:0] ph_step(
      input logic [PHASE_W-1:0] a,
      input logic               up
   );
      if (up) return (a == PH_MAX) ? '0 : a + 1'b1;
      return (a == '0) ? PH_MAX : a - 1'b1;
   endfunction

   // A step is a phasestep level change seen between two scanclk rises
   assign step_edge = sc_rise & ps_s & ~ps_prev_q;
   assign dir = (phasecounterselect == SEL_M) ? ~phaseupdown
                                              : phaseupdown;

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      busy_cnt_d = busy_cnt_q;
      acc_d      = acc_q;
      step_cnt_d = step_cnt_q;
      err_d      = err_q;
      done_d     = done_q;
      locked_d   = locked_q;
      ps_prev_d  = sc_rise ? ps_s : ps_prev_q;
`ifdef PLL_RESP_CLKSWITCH_EN
      clksrc_d   = clksrc_q;
`endif

      if (ar_s) begin
         state_d    = HOLD;
         lock_cnt_d = '0;
         busy_cnt_d = '0;
         acc_d      = '0;
         err_d      = '0;
         done_d     = 1'b0;
         locked_d   = 1'b0;
`ifdef PLL_RESP_CLKSWITCH_EN
      end else if (cs_rise && locked_q) begin
         clksrc_d   = ~clksrc_q;
         locked_d   = 1'b0;
         state_d    = LOCKING;
         lock_cnt_d = '0;
         busy_cnt_d = '0;
`endif
      end else begin
         unique case (state_q)
            HOLD: begin
               state_d    = LOCKING;
               lock_cnt_d = '0;
            end
            LOCKING: begin
               if (lock_cnt_q == LCK_W'(LOCK_CYCLES - 1)) begin
                  locked_d = 1'b1;
                  done_d   = 1'b1;
                  state_d  = IDLE;
               end else begin
                  lock_cnt_d = lock_cnt_q + 1'b1;
               end
            end
            IDLE: begin
               if (step_edge) begin
                  state_d    = BUSY;
                  busy_cnt_d = '0;
                  done_d     = 1'b0;
                  if (step_cnt_q != 16'hFFFF)
                     step_cnt_d = step_cnt_q + 1'b1;
                  if (phasecounterselect == SEL_BAD)
                     err_d[ERR_BAD_SEL] = 1'b1;
                  for (int i = 0; i < NUM_C; i++) begin
                     if (sel_hits(phasecounterselect, i))
                        acc_d[i] = ph_step(acc_q[i], dir);
                  end
               end
            end
            BUSY: begin
               if (sc_rise) begin
                  if (step_edge) err_d[ERR_OVERRUN] = 1'b1;
                  if (busy_cnt_q == 3'(DONE_LATENCY - 1)) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     busy_cnt_d = busy_cnt_q + 1'b1;
                  end
               end
            end
            default: state_d = HOLD;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HOLD;
         lock_cnt_q <= '0;
         busy_cnt_q <= '0;
         acc_q      <= '0;
         step_cnt_q <= '0;
         err_q      <= '0;
         done_q     <= 1'b0;
         locked_q   <= 1'b0;
         ps_prev_q  <= 1'b0;
`ifdef PLL_RESP_CLKSWITCH_EN
         clksrc_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         busy_cnt_q <= busy_cnt_d;
         acc_q      <= acc_d;
         step_cnt_q <= step_cnt_d;
         err_q      <= err_d;
         done_q     <= done_d;
         locked_q   <= locked_d;
         ps_prev_q  <= ps_prev_d;
`ifdef PLL_RESP_CLKSWITCH_EN
         clksrc_q   <= clksrc_d;
`endif
      end
   end

   assign phase_done = done_q;
   assign locked     = locked_q;
   assign phase_out  = acc_q;
   assign step_count = step_cnt_q;
   assign err        = err_q;
`ifdef PLL_RESP_CLKSWITCH_EN
   assign active_clksrc = clksrc_q;
`else
   assign active_clksrc = 1'b0;
`endif

endmodule

// File: tb/tb_pll_phase_responder.sv
// Bench for pll_phase_responder: directed table, corner sequences
// and randomized steps against a modulo-arithmetic model.
module tb_pll_phase_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        scanclk;
   logic        phasestep;
   logic [2:0]  phasecounterselect;
   logic        phaseupdown;
   logic        areset;
   logic        clkswitch;
   logic        phase_done;
   logic        locked;
   logic [29:0] phase_out;
   logic [15:0] step_count;
   logic [1:0]  err;
   logic        active_clksrc;

   always #5 clk = ~clk;

   pll_phase_responder dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .scanclk            (scanclk),
      .phasestep          (phasestep),
      .phasecounterselect (phasecounterselect),
      .phaseupdown        (phaseupdown),
      .areset             (areset),
      .clkswitch          (clkswitch),
      .phase_done         (phase_done),
      .locked             (locked),
      .phase_out          (phase_out),
      .step_count         (step_count),
      .err                (err),
      .active_clksrc      (active_clksrc)
   );

   typedef struct {
      logic [2:0]  sel;
      logic        up;
      logic        pre_ar;
      logic [29:0] ph;
      logic [15:0] cnt;
      logic [1:0]  er;
   } vec_t;

   vec_t tbl[7];

   int n_chk  = 0;
   int n_fail = 0;

   int          m_acc[5];
   int          m_cnt;
   logic [1:0]  m_err;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // One scanclk period (16 clk high, 16 low); done sampled after rise
   task automatic sc_pulse(input logic ps, input logic exp_done);
      phasestep = ps;
      tick(8);
      scanclk = 1'b1;
      tick(4);
      chk("phase_done", {31'd0, phase_done}, {31'd0, exp_done});
      tick(12);
      scanclk = 1'b0;
      tick(8);
   endtask

   task automatic held_step();
      sc_pulse(1'b1, 1'b0);
      sc_pulse(1'b1, 1'b0);
      sc_pulse(1'b1, 1'b1);
      sc_pulse(1'b0, 1'b1);
   endtask

   task automatic short_step();
      sc_pulse(1'b1, 1'b0);
      sc_pulse(1'b0, 1'b0);
      sc_pulse(1'b0, 1'b1);
   endtask

   function automatic logic [29:0] model_phase();
      logic [29:0] p;
      p = '0;
      for (int i = 0; i < 5; i++) p[i*6 +: 6] = 6'(m_acc[i]);
      return p;
   endfunction

   task automatic model_step(input logic [2:0] sel, input logic up);
      int d;
      if (m_cnt < 65535) m_cnt++;
      if (sel == 3'd7) begin
         m_err[0] = 1'b1;
      end else begin
         d = up ? 1 : -1;
         if (sel == 3'd1) d = -d;
         for (int i = 0; i < 5; i++)
            if (sel == 3'd0 || sel == 3'd1 || int'(sel) == i + 2)
               m_acc[i] = (m_acc[i] + d + 64) % 64;
      end
   endtask

   task automatic model_areset();
      for (int i = 0; i < 5; i++) m_acc[i] = 0;
      m_err = 2'b00;
   endtask

   task automatic lock_check();
      areset = 1'b0;
      tick(18);
      chk("locked_early", {31'd0, locked}, 32'd0);
      tick(1);
      chk("locked", {31'd0, locked}, 32'd1);
      chk("lock_done", {31'd0, phase_done}, 32'd1);
      chk("lock_phase", {2'd0, phase_out}, 32'd0);
   endtask

   initial begin
      tbl[0] = '{3'd0, 1'b1, 1'b0, {5{6'd1}}, 16'd1, 2'b00};
      tbl[1] = '{3'd0, 1'b1, 1'b0, {5{6'd2}}, 16'd2, 2'b00};
      tbl[2] = '{3'd0, 1'b1, 1'b0, {5{6'd3}}, 16'd3, 2'b00};
      tbl[3] = '{3'd1, 1'b1, 1'b0, {5{6'd2}}, 16'd4, 2'b00};
      tbl[4] = '{3'd2, 1'b1, 1'b1, 30'd1,     16'd5, 2'b00};
      tbl[5] = '{3'd3, 1'b0, 1'b0, 30'd4033,  16'd6, 2'b00};
      tbl[6] = '{3'd7, 1'b1, 1'b0, 30'd4033,  16'd7, 2'b01};

      model_areset();
      m_cnt = 0;

      rst_n              = 1'b0;
      areset             = 1'b1;
      scanclk            = 1'b0;
      phasestep          = 1'b0;
      phasecounterselect = 3'd0;
      phaseupdown        = 1'b1;
      clkswitch          = 1'b0;
      tick(3);
      chk("rst_done", {31'd0, phase_done}, 32'd0);
      chk("rst_locked", {31'd0, locked}, 32'd0);
      chk("rst_phase", {2'd0, phase_out}, 32'd0);
      chk("rst_count", {16'd0, step_count}, 32'd0);
      chk("rst_err", {30'd0, err}, 32'd0);
      chk("rst_clksrc", {31'd0, active_clksrc}, 32'd0);

      rst_n = 1'b1;
      tick(4);
      lock_check();

      for (int v = 0; v < 7; v++) begin
         if (tbl[v].pre_ar) begin
            areset = 1'b1;
            tick(4);
            lock_check();
            model_areset();
         end
         phasecounterselect = tbl[v].sel;
         phaseupdown        = tbl[v].up;
         held_step();
         model_step(tbl[v].sel, tbl[v].up);
         chk("tbl_phase", {2'd0, phase_out}, {2'd0, tbl[v].ph});
         chk("tbl_count", {16'd0, step_count}, {16'd0, tbl[v].cnt});
         chk("tbl_err", {30'd0, err}, {30'd0, tbl[v].er});
      end

      // Second step edge while BUSY is dropped and flagged
      phasecounterselect = 3'd4;
      phaseupdown        = 1'b1;
      sc_pulse(1'b1, 1'b0);
      sc_pulse(1'b0, 1'b0);
      sc_pulse(1'b1, 1'b1);
      sc_pulse(1'b0, 1'b1);
      model_step(3'd4, 1'b1);
      m_err[1] = 1'b1;
      chk("ovr_phase", {2'd0, phase_out}, 32'd8129);
      chk("ovr_count", {16'd0, step_count}, 32'd8);
      chk("ovr_err", {30'd0, err}, 32'd3);

      clkswitch = 1'b1;
      tick(4);
      clkswitch = 1'b0;
`ifdef PLL_RESP_CLKSWITCH_EN
      chk("sw_clksrc", {31'd0, active_clksrc}, 32'd1);
      chk("sw_unlock", {31'd0, locked}, 32'd0);
      tick(18);
      chk("sw_relock", {31'd0, locked}, 32'd1);
      chk("sw_phase", {2'd0, phase_out}, 32'd8129);
`else
      chk("sw_clksrc", {31'd0, active_clksrc}, 32'd0);
      chk("sw_locked", {31'd0, locked}, 32'd1);
`endif

      // areset while BUSY aborts the step in progress
      phasecounterselect = 3'd2;
      sc_pulse(1'b1, 1'b0);
      model_step(3'd2, 1'b1);
      phasestep = 1'b0;
      areset    = 1'b1;
      tick(4);
      chk("abort_phase", {2'd0, phase_out}, 32'd0);
      chk("abort_done", {31'd0, phase_done}, 32'd0);
      chk("abort_locked", {31'd0, locked}, 32'd0);
      chk("abort_err", {30'd0, err}, 32'd0);
      model_areset();
      lock_check();
      sc_pulse(1'b0, 1'b1);
      chk("abort_count", {16'd0, step_count}, m_cnt);

      for (int r = 0; r < 40; r++) begin
         logic [2:0] s;
         logic       u;
         s = 3'($urandom_range(0, 7));
         u = 1'($urandom_range(0, 1));
         phasecounterselect = s;
         phaseupdown        = u;
         short_step();
         model_step(s, u);
         chk("rnd_phase", {2'd0, phase_out}, {2'd0, model_phase()});
         chk("rnd_count", {16'd0, step_count}, m_cnt);
         chk("rnd_err", {30'd0, err}, {30'd0, m_err});
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
